// File: rtl/rom_stream.sv
// rom_stream: parametrised synchronous ROM with a registered random-access
// read port and a valid/ready burst-read engine that wraps at the top address.
// Optional feature macro: ROM_PARITY_EN adds rom_parity/out_parity outputs
// (XOR reduction of rom_out/out_data, registered with their data).
module rom_stream #(
  parameter int unsigned data_width = 8,
  parameter int unsigned addr_width = 3,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [addr_width-1:0] addr,
  output logic [data_width-1:0] rom_out,
  input  logic                  start,
  input  logic [addr_width-1:0] burst_base,
  input  logic [addr_width:0]   burst_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data,
  output logic                  busy,
  output logic                  done
`ifdef ROM_PARITY_EN
  ,
  output logic                  rom_parity,
  output logic                  out_parity
`endif
);

  localparam int unsigned DEPTH = 2 ** addr_width;
  localparam logic [addr_width:0] DEPTH_LEN = (addr_width + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  logic [data_width-1:0] mem [DEPTH];

  state_t                state;
  logic [addr_width-1:0] rd_ptr;
  logic [addr_width:0]   remaining;
  logic [addr_width:0]   len_clamped;
  logic                  load;

  // ROM contents: the 3*i+1 ramp
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
      assign mem[i] = data_width'(3 * i + 1);
    end
  endgenerate

  // Over-long bursts are clamped to one full pass over the ROM
  always_comb begin
    len_clamped = (burst_len > DEPTH_LEN) ? DEPTH_LEN : burst_len;
    load        = !out_valid || out_ready;
  end

  assign busy = (state != IDLE);

  // Random-access port: one-cycle registered read, holds when en is low
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rom_out <= '0;
`ifdef ROM_PARITY_EN
      rom_parity <= 1'b0;
`endif
    end else if (en) begin
      rom_out <= mem[addr];
`ifdef ROM_PARITY_EN
      rom_parity <= ^mem[addr];
`endif
    end
  end

  // Burst engine: IDLE -> STREAM (load words) -> DRAIN (retire last word)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
`ifdef ROM_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len_clamped == '0) begin
              done <= 1'b1;
            end else begin
              rd_ptr    <= burst_base;
              remaining <= len_clamped;
              state     <= STREAM;
            end
          end
        end
        STREAM: begin
          if (load) begin
            out_data  <= mem[rd_ptr];
`ifdef ROM_PARITY_EN
            out_parity <= ^mem[rd_ptr];
`endif
            out_valid <= 1'b1;
            rd_ptr    <= rd_ptr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == (addr_width + 1)'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_stream.sv
// tb_rom_stream: table-driven checks of the random port plus hand-written
// burst sequences (wrap, backpressure, busy start, zero length, reset, clamp).
module tb_rom_stream;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       en;
  logic [2:0] addr;
  logic [7:0] rom_out;
  logic       start;
  logic [2:0] burst_base;
  logic [3:0] burst_len;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic       done;
`ifdef ROM_PARITY_EN
  logic       rom_parity;
  logic       out_parity;
`endif

  int checks = 0;
  int errors = 0;

  rom_stream #(.data_width(8), .addr_width(3)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .en         (en),
    .addr       (addr),
    .rom_out    (rom_out),
    .start      (start),
    .burst_base (burst_base),
    .burst_len  (burst_len),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
`ifdef ROM_PARITY_EN
    ,
    .rom_parity (rom_parity),
    .out_parity (out_parity)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_word(input int unsigned a);
    return 8'((3 * (a % 8) + 1) & 8'hFF);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 repeating
  task automatic run_burst(input logic [2:0] base, input logic [3:0] len,
                           input int mode, input int exp_n, input string tag);
    int         n;
    int         dones;
    logic       stall;
    logic [7:0] held;
    n = 0; dones = 0; stall = 1'b0; held = '0;
    burst_base = base; burst_len = len; start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 1);
    check({tag, "_valid_latency"}, 32'(out_valid), 0);
    for (int cyc = 0; cyc < 80 && dones == 0; cyc++) begin
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (cyc == 1) check({tag, "_first_valid"}, 32'(out_valid), 1);
      if (stall) begin
        check({tag, "_stall_valid"}, 32'(out_valid), 1);
        check({tag, "_stall_data"}, 32'(out_data), 32'(held));
      end
      if (mode == 0 && cyc > 0) check({tag, "_no_bubble"}, 32'(out_valid), 1);
      if (out_valid && out_ready) begin
        check({tag, "_word"}, 32'(out_data), 32'(exp_word(base + n)));
`ifdef ROM_PARITY_EN
        check({tag, "_parity"}, 32'(out_parity), 32'(^exp_word(base + n)));
`endif
        n++;
      end
      stall = out_valid && !out_ready;
      held  = out_data;
      tick();
      if (done) begin
        dones++;
        check({tag, "_busy_falls_with_done"}, 32'(busy), 0);
        check({tag, "_valid_clears"}, 32'(out_valid), 0);
      end
    end
    check({tag, "_done_seen"}, 32'(dones), 1);
    check({tag, "_word_count"}, 32'(n), 32'(exp_n));
    out_ready = 1'b0;
    tick();
    check({tag, "_done_one_cycle"}, 32'(done), 0);
    check({tag, "_idle_after"}, 32'(busy), 0);
  endtask

  typedef struct {
    logic       en;
    logic [2:0] addr;
    logic [7:0] exp;
  } rvec_t;

  rvec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 3'd5, 8'h10};
    vecs[1] = '{1'b1, 3'd7, 8'h16};
    vecs[2] = '{1'b0, 3'd0, 8'h16};
    vecs[3] = '{1'b1, 3'd0, 8'h01};
    vecs[4] = '{1'b1, 3'd3, 8'h0A};
    vecs[5] = '{1'b0, 3'd5, 8'h0A};
    vecs[6] = '{1'b1, 3'd4, 8'h0D};
    vecs[7] = '{1'b1, 3'd6, 8'h13};

    reset_n = 1'b0; en = 1'b0; addr = '0; start = 1'b0;
    burst_base = '0; burst_len = '0; out_ready = 1'b0;
    #12;
    check("reset_rom_out", 32'(rom_out), 0);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_data", 32'(out_data), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    reset_n = 1'b1;
    tick();

    // Random port table
    for (int i = 0; i < 8; i++) begin
      en = vecs[i].en;
      addr = vecs[i].addr;
      tick();
      check($sformatf("rom_vec%0d", i), 32'(rom_out), 32'(vecs[i].exp));
`ifdef ROM_PARITY_EN
      check($sformatf("rom_par%0d", i), 32'(rom_parity), 32'(^vecs[i].exp));
`endif
    end
    en = 1'b0;

    // Wrapping burst, full rate then with backpressure
    run_burst(3'd6, 4'd4, 0, 4, "wrap");
    run_burst(3'd6, 4'd4, 1, 4, "bp");

    // Zero-length start: done pulse, no valid
    burst_len = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("len0_done", 32'(done), 1);
    check("len0_valid", 32'(out_valid), 0);
    check("len0_busy", 32'(busy), 0);
    tick();
    check("len0_done_clears", 32'(done), 0);

    // Start while busy must be ignored
    burst_base = 3'd0; burst_len = 4'd2; start = 1'b1; out_ready = 1'b0;
    tick();
    burst_base = 3'd5; burst_len = 4'd4;
    tick();
    start = 1'b0;
    check("busy_start_word0", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    tick();
    check("busy_start_word1", 32'(out_data), 32'h04);
    tick();
    check("busy_start_done", 32'(done), 1);
    out_ready = 1'b0;
    tick();
    check("busy_start_ignored_busy", 32'(busy), 0);
    check("busy_start_ignored_valid", 32'(out_valid), 0);

    // Reset mid-burst after two words
    en = 1'b1; addr = 3'd2;
    burst_base = 3'd2; burst_len = 4'd6; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("mid_rst_pre_data", 32'(out_data), 32'(exp_word(4)));
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_data", 32'(out_data), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_rom_out", 32'(rom_out), 0);
    en = 1'b0;
    tick();
    check("mid_rst_no_done", 32'(done), 0);
    reset_n = 1'b1;
    tick();
    check("post_rst_no_done", 32'(done), 0);
    run_burst(3'd3, 4'd3, 0, 3, "restart");

    // Full-depth burst and clamped over-long burst
    run_burst(3'd0, 4'd8, 0, 8, "full");
    run_burst(3'd6, 4'd12, 1, 8, "clamp");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
